// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the oversample rate.
// Both the transmitter and the receiver use this package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OVS = 16;

    // Stop periods longer than one bit (1.5 or 2 stop bits) count past 15.
    function automatic int tick_cnt_width(input int sb_tick);
        return (sb_tick > OVS) ? 5 : 4;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side UART signals: tick and byte/strobe in, serial line and status out.
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output s_tick, tx_start, din,
        input  tx, tx_busy, tx_done_tick
    );

    modport slave (
        input  s_tick, tx_start, din,
        output tx, tx_busy, tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, then stop, each timed by 16 s_ticks.
// tx is registered one clk behind the state; tx_start is taken only in IDLE and ignored while busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = PAR_NONE
) (
    input  logic     clk,
    input  logic     reset_n,
    uart_tx_if.slave tx_if
);

    localparam int              SW          = tick_cnt_width(SB_TICK);
    localparam logic [SW-1:0]   S_BIT_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0]   S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]      N_LAST      = 3'(DBIT - 1);

    uart_state_e     state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            p_reg, p_next;
    logic            tx_reg, tx_next;
    logic            done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            p_reg     <= p_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        p_next     = p_reg;
        tx_next    = tx_reg;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_if.tx_start) begin
                    b_next     = tx_if.din;
                    s_next     = '0;
                    p_next     = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (tx_if.s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_next = b_reg[0];
                if (tx_if.s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next = '0;
                        p_next = p_reg ^ b_reg[0];
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST) begin
                            state_next = (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            PAR: begin
                // p_reg is the XOR of the data bits, i.e. already the even-parity bit.
                tx_next = (PARITY == PAR_EVEN) ? p_reg : ~p_reg;
                if (tx_if.s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (tx_if.s_tick) begin
                    if (s_reg == S_STOP_LAST) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_if.tx           = tx_reg;
    assign tx_if.tx_busy      = (state_reg != IDLE);
    assign tx_if.tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations share one stimulus and are checked every clk against a frame-level model.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       s_tick   = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] din8     = 8'h00;
    int         tick_div = 1;
    int         tick_cnt = 0;
    int         errors   = 0;
    int         checks   = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DBIT(8)) if0 ();
    uart_tx_if #(.DBIT(8)) if1 ();
    uart_tx_if #(.DBIT(8)) if2 ();
    uart_tx_if #(.DBIT(5)) if3 ();

    assign if0.s_tick = s_tick;  assign if0.tx_start = tx_start;  assign if0.din = din8;
    assign if1.s_tick = s_tick;  assign if1.tx_start = tx_start;  assign if1.din = din8;
    assign if2.s_tick = s_tick;  assign if2.tx_start = tx_start;  assign if2.din = din8;
    assign if3.s_tick = s_tick;  assign if3.tx_start = tx_start;  assign if3.din = din8[4:0];

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(PAR_NONE)) u0 (.clk(clk), .reset_n(reset_n), .tx_if(if0));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(PAR_EVEN)) u1 (.clk(clk), .reset_n(reset_n), .tx_if(if1));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(PAR_ODD))  u2 (.clk(clk), .reset_n(reset_n), .tx_if(if2));
    uart_tx #(.DBIT(5), .SB_TICK(24), .PARITY(PAR_EVEN)) u3 (.clk(clk), .reset_n(reset_n), .tx_if(if3));

    logic tx_o [4];
    logic busy_o [4];
    logic done_o [4];

    always_comb begin
        tx_o[0] = if0.tx;  busy_o[0] = if0.tx_busy;  done_o[0] = if0.tx_done_tick;
        tx_o[1] = if1.tx;  busy_o[1] = if1.tx_busy;  done_o[1] = if1.tx_done_tick;
        tx_o[2] = if2.tx;  busy_o[2] = if2.tx_busy;  done_o[2] = if2.tx_done_tick;
        tx_o[3] = if3.tx;  busy_o[3] = if3.tx_busy;  done_o[3] = if3.tx_done_tick;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_cnt >= tick_div - 1) begin
                tick_cnt = 0;
                s_tick   = 1'b1;
            end else begin
                tick_cnt++;
                s_tick = 1'b0;
            end
        end
    end

    function automatic int db_of(input int i);  return (i == 3) ? 5 : 8;  endfunction
    function automatic int sb_of(input int i);  return (i == 3) ? 24 : 16; endfunction
    function automatic int par_of(input int i);
        case (i)
            0:       return PAR_NONE;
            2:       return PAR_ODD;
            default: return PAR_EVEN;
        endcase
    endfunction
    function automatic int nb_of(input int i);  return 2 + db_of(i) + ((par_of(i) != PAR_NONE) ? 1 : 0); endfunction
    function automatic int flen_of(input int i); return 16 * (nb_of(i) - 1) + sb_of(i); endfunction

    // Line level of every bit slot: start, data LSB first, parity, stop (padding is idle-high).
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input int dbit, input int par);
        logic [10:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int j = 0; j < dbit; j++) begin
            f[1 + j] = d[j];
            p        = p ^ d[j];
        end
        if (par != PAR_NONE) f[1 + dbit] = (par == PAR_EVEN) ? p : ~p;
        return f;
    endfunction

    logic [10:0] m_frame [4];
    logic        m_busy [4];
    logic        m_tx [4];
    int          m_t [4];

    function automatic logic lvl_at(input int i, input int t);
        int idx;
        idx = t / 16;
        if (idx > nb_of(i) - 1) idx = nb_of(i) - 1;
        return m_frame[i][idx];
    endfunction

    // Model: a frame is a tick count since acceptance; tx shows the slot of the previous cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] <= 1'b0;
                m_tx[i]   <= 1'b1;
                m_t[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_tx[i] <= m_busy[i] ? lvl_at(i, m_t[i]) : 1'b1;
                if (!m_busy[i]) begin
                    if (tx_start) begin
                        m_frame[i] <= mk_frame(din8, db_of(i), par_of(i));
                        m_busy[i]  <= 1'b1;
                        m_t[i]     <= 0;
                    end
                end else if (s_tick) begin
                    if (m_t[i] == flen_of(i) - 1) m_busy[i] <= 1'b0;
                    else                          m_t[i]    <= m_t[i] + 1;
                end
            end
        end
    end

    task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0b required=%0b at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk1("tx", i, tx_o[i], m_tx[i]);
            chk1("tx_busy", i, busy_o[i], m_busy[i]);
            chk1("tx_done_tick", i, done_o[i], m_busy[i] && s_tick && (m_t[i] == flen_of(i) - 1));
        end
    end

    logic tr_tx [4][800];
    logic tr_busy [4][800];
    logic tr_done [4][800];

    // Entry c holds the outputs just after the c-th rising edge following the current one.
    task automatic record(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                tr_tx[i][c]   = tx_o[i];
                tr_busy[i][c] = busy_o[i];
                tr_done[i][c] = done_o[i];
            end
        end
    endtask

    function automatic logic [9:0] frame_bits(input int i, input int base);
        logic [9:0] v;
        for (int b = 0; b < 10; b++) v[b] = tr_tx[i][base + 16 * b + 9];
        return v;
    endfunction

    function automatic int count_done(input int i, input int n);
        int k;
        k = 0;
        for (int c = 1; c <= n; c++) if (tr_done[i][c] === 1'b1) k++;
        return k;
    endfunction

    function automatic int first_at(input int i, input int from, input logic val, input int n);
        for (int c = from; c <= n; c++) if (tr_tx[i][c] === val) return c;
        return -1;
    endfunction

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        din8     = d;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        logic any;
        any = 1'b1;
        for (int c = 0; c < bound && any; c++) begin
            @(negedge clk);
            any = busy_o[0] | busy_o[1] | busy_o[2] | busy_o[3];
        end
        chk1("idle_timeout", 0, any, 1'b0);
    endtask

    initial begin
        int f, r, f2, r2, run;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk1("reset_tx", i, tx_o[i], 1'b1);
            chk1("reset_busy", i, busy_o[i], 1'b0);
            chk1("reset_done", i, done_o[i], 1'b0);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tick every clk, 0xA5.
        pulse_start(8'hA5);
        record(200);
        chk_v("a5_frame", 32'(frame_bits(0, 0)), 32'({1'b1, 8'hA5, 1'b0}));
        chk1("a5_done_at_159", 0, tr_done[0][159], 1'b1);
        chk_v("a5_done_count", count_done(0, 200), 1);
        chk1("a5_busy_159", 0, tr_busy[0][159], 1'b1);
        chk1("a5_busy_160", 0, tr_busy[0][160], 1'b0);
        chk1("even_parity_bit", 1, tr_tx[1][153], 1'b0);
        chk1("odd_parity_bit", 2, tr_tx[2][153], 1'b1);
        chk1("even_done_at_175", 1, tr_done[1][175], 1'b1);
        chk1("odd_done_at_175", 2, tr_done[2][175], 1'b1);
        chk1("dbit5_parity_bit", 3, tr_tx[3][105], 1'b0);
        chk1("dbit5_done_at_135", 3, tr_done[3][135], 1'b1);
        wait_idle(50);

        // Tick every third clk, 0x01.
        tick_div = 3;
        pulse_start(8'h01);
        record(700);
        f  = first_at(0, 1, 1'b0, 700);
        r  = first_at(0, f + 1, 1'b1, 700);
        f2 = first_at(0, r + 1, 1'b0, 700);
        r2 = first_at(0, f2 + 1, 1'b1, 700);
        chk_v("div3_bit0_clks", f2 - r, 48);
        chk_v("div3_bits1to7_clks", r2 - f2, 336);
        chk_v("div3_done_count", count_done(0, 700), 1);
        wait_idle(100);
        tick_div = 1;

        // Re-strobe with 0xFF while busy.
        pulse_start(8'h3C);
        fork
            record(200);
            begin
                repeat (40) @(negedge clk);
                tx_start = 1'b1;
                din8     = 8'hFF;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        chk_v("restart_frame", 32'(frame_bits(0, 0)), 32'({1'b1, 8'h3C, 1'b0}));
        chk_v("restart_done_count", count_done(0, 200), 1);
        chk1("restart_idle_after", 0, tr_busy[0][200], 1'b0);
        wait_idle(50);

        // tx_start held high: 0x00 then 0x55 back to back.
        @(negedge clk);
        tx_start = 1'b1;
        din8     = 8'h00;
        @(negedge clk);
        fork
            record(400);
            begin
                @(negedge clk);
                din8 = 8'h55;
                repeat (164) @(negedge clk);
                tx_start = 1'b0;
            end
        join
        run = 0;
        for (int c = 145; c < 400 && tr_tx[0][c] === 1'b1; c++) run++;
        chk1("b2b_last_data", 0, tr_tx[0][144], 1'b0);
        chk_v("b2b_high_run", run, 17);
        chk1("b2b_gap_idle", 0, tr_busy[0][160], 1'b0);
        chk1("b2b_restart_busy", 0, tr_busy[0][161], 1'b1);
        chk1("b2b_second_start", 0, tr_tx[0][162], 1'b0);
        chk_v("b2b_frame2", 32'(frame_bits(0, 161)), 32'({1'b1, 8'h55, 1'b0}));
        chk_v("b2b_done_count", count_done(0, 400), 2);
        wait_idle(100);

        // Asynchronous reset during data bit 3.
        pulse_start(8'h5A);
        fork
            record(120);
            begin
                repeat (70) @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                for (int i = 0; i < 4; i++) begin
                    chk1("async_rst_tx", i, tx_o[i], 1'b1);
                    chk1("async_rst_busy", i, busy_o[i], 1'b0);
                end
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        chk1("rst_was_busy", 0, tr_busy[0][70], 1'b1);
        chk_v("rst_no_done", count_done(0, 120) + count_done(1, 120) + count_done(2, 120) + count_done(3, 120), 0);
        pulse_start(8'hC3);
        record(200);
        chk_v("post_rst_frame", 32'(frame_bits(0, 0)), 32'({1'b1, 8'hC3, 1'b0}));
        chk1("post_rst_done_at_159", 0, tr_done[0][159], 1'b1);
        wait_idle(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter driven by the 16x oversampling tick from the shared baud-rate counter (`s_tick` = that counter's `max_tick`). It accepts a parallel byte with a one-cycle start strobe and shifts out one frame, LSB first: a start bit, DBIT data bits, an optional parity bit, then the stop bit(s). It sits on the transmit side of the UART, opposite the receiver, and shares the tick source with it.

## Interface
- `DBIT`, 8: number of data bits, 5..8.
- `SB_TICK`, 16: s_ticks spent in stop; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.

- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  one-clk-wide oversample tick, 16 per bit time.
- `tx_start`  in  1  start strobe; sampled only in IDLE.
- `din`  in  DBIT  byte to send; captured when tx_start is accepted.
- `tx`  out  1  serial line; registered, idle high.
- `tx_busy`  out  1  high whenever the state is not IDLE.
- `tx_done_tick`  out  1  one-clk pulse at the end of the stop period.

## Operation
- States are IDLE, START, DATA, PAR and STOP.
- Internal registers:
  - `s_reg`: 4-bit tick counter; holds 5 bits when SB_TICK > 16.
  - `n_reg`: 3-bit bit counter.
  - `b_reg`: DBIT shift register.
  - `p_reg`: running parity.
  - `tx_reg`.
- IDLE:
  - `tx_next`=1.
  - If tx_start=1: capture din into b_reg, set s=0 and p=0, go to START. No s_tick is needed.
- START:
  - `tx_next`=0.
  - On each s_tick: if s==15, set s=0 and n=0 and go to DATA; else s+1.
- DATA:
  - `tx_next`=b_reg[0].
  - On s_tick with s==15: set s=0, p ^= b_reg[0], shift b_reg right.
  - At that point, if n==DBIT-1, go to PAR (PARITY≠0) or STOP; else n+1.
- PAR:
  - `tx_next`=p_reg for even parity, ~p_reg for odd.
  - On s_tick with s==15: set s=0 and go to STOP.
- STOP:
  - `tx_next`=1.
  - On s_tick with s==SB_TICK-1: assert tx_done_tick combinationally in that cycle, and go to IDLE.
- s_tick low: all counters and the state hold.
- tx_start while busy: ignored. din changes after acceptance have no effect.
- tx_start high in the cycle after returning to IDLE: a new frame starts immediately (back-to-back frames).
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, counters=0, b_reg=0, tx_reg=1.
  - Therefore tx=1, tx_busy=0, tx_done_tick=0.
  - The frame in flight is abandoned with no done pulse.

## Timing
- Acceptance: tx_start high before edge k puts the block in START at edge k.
- tx lags the state by one clock:
  - tx falls at edge k+1.
  - tx_busy rises at edge k, since it decodes the state.
- Every bit lasts exactly 16 s_ticks; stop lasts SB_TICK s_ticks.
- Frame length = 16·(1+DBIT+(PARITY≠0)) + SB_TICK s_ticks.
- tx_done_tick is coincident with the last stop s_tick. The state is IDLE at the following edge. tx is already 1.
- No combinational path from din to any output.

## Structure
- Shared `uart_pkg` holds:
  - state encoding constants (IDLE, START, DATA, PAR, STOP);
  - parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2);
  - oversample constant OVS=16, also used by the receiver.
- Single module. No sub-module is natural.
- The baud tick generator is instantiated at the UART top level, not inside this block.
- State plus datapath uses the usual `_reg`/`_next` register and next-state split.

## Test plan
- s_tick tied 1, DBIT=8, PARITY=0, din=0xA5, one tx_start pulse:
  - tx shows 0,1,0,1,0,0,1,0,1,1, each bit 16 clks.
  - tx_done_tick pulses once, 160 clks after the start bit begins.
  - tx_busy falls the next clk.
- Same stimulus with PARITY=2: parity bit = 0. With PARITY=1: parity bit = 1. Frame length is 176 ticks.
- s_tick every 3rd clk (tick counter M=3), din=0x01:
  - each bit is held 48 clks;
  - tx never changes between ticks.
- tx_start re-pulsed with din=0xFF mid-frame:
  - ignored;
  - the original byte is transmitted intact.
- tx_start held high continuously with din=0x00 then 0x55:
  - two back-to-back frames;
  - exactly one idle-high clk between the stop period and the next start bit.
- reset_n asserted during data bit 3:
  - tx=1 and tx_busy=0 immediately (asynchronously);
  - no tx_done_tick;
  - after release, a fresh tx_start sends a full correct frame.
